// File: rtl/cluster_chk_pkg.sv
// Shared state encoding, latency limit and width helper for the cluster step checker.
package cluster_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_CMP  = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  localparam int unsigned PRED_LAT_MAX = 15;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/cluster_step_checker_if.sv
// Upstream vector, predictor-bank, result and counter signals of the cluster step checker.
interface cluster_step_checker_if #(
  parameter int unsigned IN_W  = 1894,
  parameter int unsigned OUT_W = 1894,
  parameter int unsigned CNT_W = 32,
  parameter int unsigned IDX_W = 11
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_vec;
  logic [OUT_W-1:0] gold_vec;
  logic [IN_W-1:0]  pred_i;
  logic [OUT_W-1:0] pred_o;
  logic             res_valid;
  logic             res_ready;
  logic             res_match;
  logic [IDX_W-1:0] res_bad_idx;
  logic [IDX_W-1:0] res_bad_cnt;
  logic             clr_cnt;
  logic [CNT_W-1:0] test_cnt;
  logic [CNT_W-1:0] err_cnt;

  modport master (
    output in_valid, in_vec, gold_vec, pred_o, res_ready, clr_cnt,
    input  in_ready, pred_i, res_valid, res_match, res_bad_idx, res_bad_cnt, test_cnt, err_cnt
  );

  modport slave (
    input  in_valid, in_vec, gold_vec, pred_o, res_ready, clr_cnt,
    output in_ready, pred_i, res_valid, res_match, res_bad_idx, res_bad_cnt, test_cnt, err_cnt
  );
endinterface

// File: rtl/mismatch_scan.sv
// Lowest-set-bit encoder and saturating population count over a mismatch vector.
module mismatch_scan
  import cluster_chk_pkg::*;
#(
  parameter int unsigned W     = 1894,
  parameter int unsigned IDX_W = 11
) (
  input  logic [W-1:0]     diff,
  output logic [IDX_W-1:0] first_idx,
  output logic             any,
  output logic [IDX_W-1:0] pop_cnt
);
  localparam int unsigned SEL_W = (clog2(W) > 0) ? clog2(W) : 1;
  localparam int unsigned PC_W  = clog2(W + 1);

  logic [PC_W-1:0] pc;

  // Walk downward so the last hit written is the lowest set bit.
  always_comb begin
    first_idx = '0;
    pc        = '0;
    for (int i = int'(W) - 1; i >= 0; i--) begin
      if (diff[i[SEL_W-1:0]]) first_idx = IDX_W'(i);
      pc = pc + PC_W'(diff[i[SEL_W-1:0]]);
    end
  end

  assign any = |diff;

  if (PC_W > IDX_W) begin : g_sat
    assign pop_cnt = (pc > PC_W'({IDX_W{1'b1}})) ? '1 : pc[IDX_W-1:0];
  end else begin : g_nosat
    assign pop_cnt = IDX_W'(pc);
  end

endmodule

// File: rtl/cluster_step_checker.sv
// Drives one latched state vector into the predictor bank and scores its outputs against gold.
//   state   | meaning
//   IDLE    | ready for a new vector, pred_i holds the previous test
//   WAIT    | bank settling, wcnt counts down PRED_LAT cycles
//   CMP     | diff captured, register result and bump counters
//   RESP    | result valid, held until res_ready
module cluster_step_checker
  import cluster_chk_pkg::*;
#(
  parameter int unsigned IN_W     = 1894,
  parameter int unsigned OUT_W    = 1894,
  parameter int unsigned PRED_LAT = 1,
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned IDX_W    = 11
) (
  input logic                 clk,
  input logic                 rst,
  cluster_step_checker_if.slave bus
);
  localparam int unsigned WCNT_W = clog2(PRED_LAT_MAX + 1);

  state_e            state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [IN_W-1:0]   pred_q, pred_d;
  logic [OUT_W-1:0]  gold_q, gold_d;
  logic [OUT_W-1:0]  diff_q, diff_d;
  logic              match_q, match_d;
  logic [IDX_W-1:0]  bad_idx_q, bad_idx_d;
  logic [IDX_W-1:0]  bad_cnt_q, bad_cnt_d;
  logic [CNT_W-1:0]  test_q, test_d;
  logic [CNT_W-1:0]  err_q, err_d;

  logic [IDX_W-1:0]  scan_idx;
  logic [IDX_W-1:0]  scan_pop;
  logic              scan_any;

  mismatch_scan #(.W(OUT_W), .IDX_W(IDX_W)) u_scan (
    .diff      (diff_q),
    .first_idx (scan_idx),
    .any       (scan_any),
    .pop_cnt   (scan_pop)
  );

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    pred_d    = pred_q;
    gold_d    = gold_q;
    diff_d    = diff_q;
    match_d   = match_q;
    bad_idx_d = bad_idx_q;
    bad_cnt_d = bad_cnt_q;
    test_d    = test_q;
    err_d     = err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          pred_d  = bus.in_vec;
          gold_d  = bus.gold_vec;
          wcnt_d  = WCNT_W'(PRED_LAT - 1);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        wcnt_d = wcnt_q - WCNT_W'(1);
        if (wcnt_q == '0) begin
          diff_d  = bus.pred_o ^ gold_q;
          state_d = ST_CMP;
        end
      end
      ST_CMP: begin
        match_d   = ~scan_any;
        bad_idx_d = scan_idx;
        bad_cnt_d = scan_pop;
        if (test_q != '1) test_d = test_q + CNT_W'(1);
        if (scan_any && (err_q != '1)) err_d = err_q + CNT_W'(1);
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (bus.res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A clear on the CMP edge discards that test's increment.
    if (bus.clr_cnt) begin
      test_d = '0;
      err_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      wcnt_q    <= '0;
      pred_q    <= '0;
      gold_q    <= '0;
      diff_q    <= '0;
      match_q   <= 1'b0;
      bad_idx_q <= '0;
      bad_cnt_q <= '0;
      test_q    <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      pred_q    <= pred_d;
      gold_q    <= gold_d;
      diff_q    <= diff_d;
      match_q   <= match_d;
      bad_idx_q <= bad_idx_d;
      bad_cnt_q <= bad_cnt_d;
      test_q    <= test_d;
      err_q     <= err_d;
    end
  end

  assign bus.in_ready    = (state_q == ST_IDLE) && !rst;
  assign bus.pred_i      = pred_q;
  assign bus.res_valid   = (state_q == ST_RESP);
  assign bus.res_match   = match_q;
  assign bus.res_bad_idx = bad_idx_q;
  assign bus.res_bad_cnt = bad_cnt_q;
  assign bus.test_cnt    = test_q;
  assign bus.err_cnt     = err_q;

endmodule

// File: tb/tb_cluster_step_checker.sv
// Directed vector table plus hand sequences for backpressure, counter clear, mid-WAIT reset and saturation.
module tb_cluster_step_checker;
  localparam int unsigned W  = 1894;
  localparam int unsigned IW = 11;

  typedef struct {
    string        name;
    logic [31:0]  seed;
    int           f0;
    int           f1;
    int           f2;
    bit           all_flip;
    logic         exp_match;
    logic [IW-1:0] exp_idx;
    logic [IW-1:0] exp_cnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst1;
  logic rst4;
  always #5 clk = ~clk;

  cluster_step_checker_if #(.IN_W(W), .OUT_W(W), .CNT_W(32), .IDX_W(IW)) bus1 ();
  cluster_step_checker_if #(.IN_W(W), .OUT_W(W), .CNT_W(2),  .IDX_W(IW)) bus4 ();

  cluster_step_checker #(.IN_W(W), .OUT_W(W), .PRED_LAT(1), .CNT_W(32), .IDX_W(IW)) dut1 (
    .clk (clk), .rst (rst1), .bus (bus1)
  );
  cluster_step_checker #(.IN_W(W), .OUT_W(W), .PRED_LAT(4), .CNT_W(2), .IDX_W(IW)) dut4 (
    .clk (clk), .rst (rst4), .bus (bus4)
  );

  // Predictor bank stand-in: a fixed XOR key, so gold = in ^ key ^ flips.
  logic [W-1:0] key;
  assign bus1.pred_o = bus1.pred_i ^ key;
  assign bus4.pred_o = bus4.pred_i ^ key;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] pattern(input logic [31:0] seed);
    logic [W-1:0] v;
    v = '0;
    for (int k = 0; k < 60; k++) v = (v << 32) | W'(seed ^ (32'h9e37_79b9 * 32'(k)));
    return v;
  endfunction

  function automatic logic [W-1:0] onehot(input int pos);
    logic [W-1:0] one;
    one = W'(1);
    return (pos < 0) ? '0 : (one << pos);
  endfunction

  task automatic run1(input logic [W-1:0] v, input logic [W-1:0] flip, output int lat);
    bus1.in_vec   = v;
    bus1.gold_vec = v ^ key ^ flip;
    bus1.in_valid = 1'b1;
    tick();
    bus1.in_valid = 1'b0;
    lat = 1;
    while (!bus1.res_valid && lat < 30) begin
      tick();
      lat++;
    end
  endtask

  task automatic run4(input logic [W-1:0] v, input logic [W-1:0] flip, output int lat);
    bus4.in_vec   = v;
    bus4.gold_vec = v ^ key ^ flip;
    bus4.in_valid = 1'b1;
    tick();
    bus4.in_valid = 1'b0;
    lat = 1;
    while (!bus4.res_valid && lat < 30) begin
      tick();
      lat++;
    end
  endtask

  task automatic hs1(input string nm);
    bus1.res_ready = 1'b1;
    tick();
    bus1.res_ready = 1'b0;
    chk({nm, "_valid_fall"}, 64'(bus1.res_valid), 64'd0);
    chk({nm, "_ready_back"}, 64'(bus1.in_ready), 64'd1);
  endtask

  task automatic hs4(input string nm);
    bus4.res_ready = 1'b1;
    tick();
    bus4.res_ready = 1'b0;
    chk({nm, "_valid_fall"}, 64'(bus4.res_valid), 64'd0);
  endtask

  vec_t tv[7];
  int   lat;
  int   exp_test;
  int   exp_err;
  logic [W-1:0] flip;

  initial begin
    tv[0] = '{"match_a",     32'h1234_5678, -1,   -1,   -1,   1'b0, 1'b1, 11'd0,    11'd0};
    tv[1] = '{"mis_73_1800", 32'hdead_beef, 73,   1800, -1,   1'b0, 1'b0, 11'd73,   11'd2};
    tv[2] = '{"mis_bit0",    32'h0000_0000, 0,    -1,   -1,   1'b0, 1'b0, 11'd0,    11'd1};
    tv[3] = '{"mis_top",     32'hffff_ffff, 1893, -1,   -1,   1'b0, 1'b0, 11'd1893, 11'd1};
    tv[4] = '{"mis_three",   32'h5a5a_a5a5, 1000, 999,  1893, 1'b0, 1'b0, 11'd999,  11'd3};
    tv[5] = '{"mis_all",     32'h0f0f_0f0f, -1,   -1,   -1,   1'b1, 1'b0, 11'd0,    11'd1894};
    tv[6] = '{"match_b",     32'h8000_0001, -1,   -1,   -1,   1'b0, 1'b1, 11'd0,    11'd0};

    key = pattern(32'hc0ff_ee11);
    bus1.in_valid = 1'b0; bus1.res_ready = 1'b0; bus1.clr_cnt = 1'b0;
    bus1.in_vec = '0;     bus1.gold_vec = '0;
    bus4.in_valid = 1'b0; bus4.res_ready = 1'b0; bus4.clr_cnt = 1'b0;
    bus4.in_vec = '0;     bus4.gold_vec = '0;

    // Reset: three cycles high, then everything zero.
    rst1 = 1'b1;
    rst4 = 1'b1;
    repeat (3) tick();
    chk("rst_in_ready",  64'(bus1.in_ready),    64'd0);
    chk("rst_res_valid", 64'(bus1.res_valid),   64'd0);
    chk("rst_pred_zero", 64'(bus1.pred_i === '0), 64'd1);
    chk("rst_match",     64'(bus1.res_match),   64'd0);
    chk("rst_bad_idx",   64'(bus1.res_bad_idx), 64'd0);
    chk("rst_bad_cnt",   64'(bus1.res_bad_cnt), 64'd0);
    chk("rst_test_cnt",  64'(bus1.test_cnt),    64'd0);
    chk("rst_err_cnt",   64'(bus1.err_cnt),     64'd0);
    chk("rst4_in_ready", 64'(bus4.in_ready),    64'd0);
    rst1 = 1'b0;
    rst4 = 1'b0;
    #1;
    chk("rel_in_ready",  64'(bus1.in_ready),    64'd1);
    chk("rel_test_cnt",  64'(bus1.test_cnt),    64'd0);
    chk("rel4_in_ready", 64'(bus4.in_ready),    64'd1);

    // Vector table, PRED_LAT=1.
    exp_test = 0;
    exp_err  = 0;
    for (int t = 0; t < 7; t++) begin
      flip = tv[t].all_flip ? '1 : (onehot(tv[t].f0) | onehot(tv[t].f1) | onehot(tv[t].f2));
      chk({tv[t].name, "_in_ready"}, 64'(bus1.in_ready), 64'd1);
      run1(pattern(tv[t].seed), flip, lat);
      exp_test++;
      if (!tv[t].exp_match) exp_err++;
      chk({tv[t].name, "_latency"}, 64'(lat),                64'd3);
      chk({tv[t].name, "_match"},   64'(bus1.res_match),     64'(tv[t].exp_match));
      chk({tv[t].name, "_bad_idx"}, 64'(bus1.res_bad_idx),   64'(tv[t].exp_idx));
      chk({tv[t].name, "_bad_cnt"}, 64'(bus1.res_bad_cnt),   64'(tv[t].exp_cnt));
      chk({tv[t].name, "_test"},    64'(bus1.test_cnt),      64'(exp_test));
      chk({tv[t].name, "_err"},     64'(bus1.err_cnt),       64'(exp_err));
      chk({tv[t].name, "_busy"},    64'(bus1.in_ready),      64'd0);
      hs1(tv[t].name);
    end

    // Backpressure: result held 10 cycles while a new vector waits upstream.
    run1(pattern(32'h1111_2222), onehot(10) | onehot(20), lat);
    exp_test++;
    exp_err++;
    chk("bp_latency", 64'(lat), 64'd3);
    bus1.in_vec   = pattern(32'h3333_4444);
    bus1.gold_vec = pattern(32'h3333_4444) ^ key;
    bus1.in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("bp_valid",    64'(bus1.res_valid),   64'd1);
      chk("bp_in_ready", 64'(bus1.in_ready),    64'd0);
      chk("bp_match",    64'(bus1.res_match),   64'd0);
      chk("bp_bad_idx",  64'(bus1.res_bad_idx), 64'd10);
      chk("bp_bad_cnt",  64'(bus1.res_bad_cnt), 64'd2);
    end
    chk("bp_test_held", 64'(bus1.test_cnt), 64'(exp_test));
    bus1.res_ready = 1'b1;
    tick();
    bus1.res_ready = 1'b0;
    chk("bp_hs_valid_fall", 64'(bus1.res_valid), 64'd0);
    chk("bp_hs_in_ready",   64'(bus1.in_ready),  64'd1);
    tick();
    bus1.in_valid = 1'b0;
    chk("bp_next_taken", 64'(bus1.in_ready), 64'd0);
    lat = 1;
    while (!bus1.res_valid && lat < 30) begin
      tick();
      lat++;
    end
    exp_test++;
    chk("bp2_latency", 64'(lat),             64'd3);
    chk("bp2_match",   64'(bus1.res_match),  64'd1);
    chk("bp2_test",    64'(bus1.test_cnt),   64'(exp_test));
    chk("bp2_err",     64'(bus1.err_cnt),    64'(exp_err));
    hs1("bp2");

    // clr_cnt on the CMP cycle beats that test's increment.
    bus1.in_vec   = pattern(32'h5555_6666);
    bus1.gold_vec = pattern(32'h5555_6666) ^ key ^ onehot(500);
    bus1.in_valid = 1'b1;
    tick();
    bus1.in_valid = 1'b0;
    tick();
    chk("clr_pre_valid", 64'(bus1.res_valid), 64'd0);
    bus1.clr_cnt = 1'b1;
    tick();
    bus1.clr_cnt = 1'b0;
    exp_test = 0;
    exp_err  = 0;
    chk("clr_valid",   64'(bus1.res_valid),   64'd1);
    chk("clr_match",   64'(bus1.res_match),   64'd0);
    chk("clr_bad_idx", 64'(bus1.res_bad_idx), 64'd500);
    chk("clr_test",    64'(bus1.test_cnt),    64'(exp_test));
    chk("clr_err",     64'(bus1.err_cnt),     64'(exp_err));
    hs1("clr");
    run1(pattern(32'h7777_8888), '0, lat);
    exp_test++;
    chk("post_clr_test", 64'(bus1.test_cnt), 64'(exp_test));
    chk("post_clr_err",  64'(bus1.err_cnt),  64'(exp_err));
    hs1("post_clr");

    // PRED_LAT=4: reset in the middle of WAIT drops the test.
    bus4.in_vec   = pattern(32'h2468_ace0);
    bus4.gold_vec = pattern(32'h2468_ace0) ^ key;
    bus4.in_valid = 1'b1;
    tick();
    bus4.in_valid = 1'b0;
    tick();
    chk("rw_busy", 64'(bus4.in_ready), 64'd0);
    rst4 = 1'b1;
    tick();
    rst4 = 1'b0;
    #1;
    chk("rw_idle",      64'(bus4.in_ready),      64'd1);
    chk("rw_test",      64'(bus4.test_cnt),      64'd0);
    chk("rw_pred_zero", 64'(bus4.pred_i === '0), 64'd1);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("rw_no_valid", 64'(bus4.res_valid), 64'd0);
    end
    run4(pattern(32'h1357_9bdf), '0, lat);
    chk("rw_next_latency", 64'(lat),            64'd6);
    chk("rw_next_match",   64'(bus4.res_match), 64'd1);
    chk("rw_next_test",    64'(bus4.test_cnt),  64'd1);
    chk("rw_next_err",     64'(bus4.err_cnt),   64'd0);
    hs4("rw_next");

    // Two-bit counters saturate at 3.
    exp_test = 1;
    exp_err  = 0;
    for (int k = 0; k < 4; k++) begin
      run4(pattern(32'h0bad_0000 + 32'(k)), onehot(100 + k), lat);
      if (exp_test < 3) exp_test++;
      if (exp_err < 3) exp_err++;
      chk("sat_latency", 64'(lat),              64'd6);
      chk("sat_bad_idx", 64'(bus4.res_bad_idx), 64'(100 + k));
      chk("sat_test",    64'(bus4.test_cnt),    64'(exp_test));
      chk("sat_err",     64'(bus4.err_cnt),     64'(exp_err));
      hs4("sat");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
